pixel_write_queue: RTL and testbench

- Buffers pixel-write requests from the game/draw FSM and drains them into the frame-buffer write port (15-bit address, 24-bit RGB, one-cycle write strobe).
- Decouples the draw FSM from port availability: the FSM pushes clear/draw writes back-to-back, and the queue issues them only when the frame buffer grants access.
- Sits directly downstream of the game FSM and upstream of the VGA frame driver's write interface.

---
 rtl/pixel_write_queue.sv | 228 ++++++++++++++++++++++
 tb/tb_pixel_write_queue.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_queue.sv
// -----------------------------------------------------------------------------
// pixel_write_queue
//
// Purpose:
//   Small FIFO between the game/draw FSM and the frame-buffer write port.
//   The draw FSM pushes clear/draw pixel writes back-to-back. The queue
//   forwards them to the frame buffer only in cycles where the frame buffer
//   grants access (fb_allow). Writes to addresses outside the frame buffer
//   are accepted, discarded and counted.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active low
//   in_valid    request present
//   in_ready    queue can accept a request (== !full)
//   in_addr     pixel address of the request
//   in_data     pixel colour of the request (RGB 8:8:8)
//   flush       discard every queued entry
//   fb_allow    frame-buffer write port available this cycle
//   fb_addr     write address to the frame buffer (holds while fb_we == 0)
//   fb_data     write data to the frame buffer (holds while fb_we == 0)
//   fb_we       one-cycle write strobe per issued entry
//   level       current occupancy, 0..DEPTH
//   empty       level == 0
//   full        level == DEPTH
//   drop_count  illegal-address requests discarded, saturates at 255
// -----------------------------------------------------------------------------
module pixel_write_queue #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 24,
  parameter int DEPTH     = 16,
  parameter int MEM_WORDS = 19200
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_W-1:0]           in_addr,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        flush,
  input  logic                        fb_allow,
  output logic [ADDR_W-1:0]           fb_addr,
  output logic [DATA_W-1:0]           fb_data,
  output logic                        fb_we,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        empty,
  output logic                        full,
  output logic [7:0]                  drop_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  // One extra bit so the limit itself (e.g. 19200) is representable even
  // when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] ADDR_LIMIT = MEM_WORDS[ADDR_W:0];
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [7:0]          drop_q, drop_d;
  logic                fb_we_q;
  logic [ADDR_W-1:0]   fb_addr_q;
  logic [DATA_W-1:0]   fb_data_q;

  // Entry storage; contents are never reset, only the pointers are.
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [ENTRY_W-1:0]  head_entry;

  // ---------------------------------------------------------------------------
  // Handshake and event decode
  // ---------------------------------------------------------------------------
  logic queue_empty;
  logic queue_full;
  logic push_hs;
  logic addr_legal;
  logic store;
  logic drop_inc;
  logic pop;

  assign queue_empty = (level_q == '0);
  assign queue_full  = (level_q == LVL_FULL);

  // in_ready depends only on registered level, so a pop in the same cycle
  // never opens a slot for a push while full.
  assign push_hs    = in_valid && !queue_full;
  assign addr_legal = ({1'b0, in_addr} < ADDR_LIMIT);

  // A flush swallows a concurrent push: the handshake still completes, but
  // the entry is neither stored nor counted as dropped.
  assign store    = push_hs && addr_legal && !flush;
  assign drop_inc = push_hs && !addr_legal && !flush;

  // No pop on the flush edge or during the FLUSH recovery cycle.
  assign pop = (state_q != S_FLUSH) && !flush && !queue_empty && fb_allow;

  assign head_entry = mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Pointer / level / counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (store) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({store, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end

    if (drop_inc && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;

    if (flush) begin
      state_d = S_FLUSH;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (store) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (level_d == '0) begin
            state_d = S_IDLE;
          end else if (!fb_allow) begin
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          // The pop for this transition happens on the same edge.
          if (fb_allow) begin
            state_d = S_DRAIN;
          end
        end
        S_FLUSH: begin
          // A push landing in the recovery cycle must not be stranded in IDLE.
          state_d = store ? S_DRAIN : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      drop_q    <= '0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      fb_we_q  <= pop;
      // Address/data only move on a pop so they hold between strobes.
      if (pop) begin
        fb_addr_q <= head_entry[ENTRY_W-1:DATA_W];
        fb_data_q <= head_entry[DATA_W-1:0];
      end
    end
  end

  // Entry write port.
  always_ff @(posedge clk) begin
    if (rst && store) begin
      mem_q[wr_ptr_q] <= {in_addr, in_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready   = !queue_full;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_we      = fb_we_q;
  assign level      = level_q;
  assign empty      = queue_empty;
  assign full       = queue_full;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
module tb_pixel_write_queue;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 24;
  localparam int DEPTH     = 16;
  localparam int MEM_WORDS = 19200;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              fb_allow;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic              fb_we;
  logic [4:0]        level;
  logic              empty;
  logic              full;
  logic [7:0]        drop_count;

  always #5 clk = ~clk;

  pixel_write_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .flush(flush), .fb_allow(fb_allow),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .level(level), .empty(empty), .full(full), .drop_count(drop_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model + scoreboard (updated on each rising edge from bench inputs)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   m_lvl   = 0;
  int   m_drop  = 0;
  bit   m_we    = 0;
  int   acc_cnt = 0;   // accepted handshakes since time zero
  int   we_cnt  = 0;   // fb_we pulses seen by the monitor
  int   max_lvl = 0;
  bit   mon_en  = 0;

  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (!rst) begin
      m_lvl = 0; m_drop = 0; m_we = 0;
      sb.delete();
    end else if (flush) begin
      if (in_valid && m_lvl < DEPTH) acc_cnt++;
      m_lvl = 0; m_we = 0;
      sb.delete();
    end else begin
      do_push = in_valid && (m_lvl < DEPTH);
      do_pop  = fb_allow && (m_lvl > 0);
      m_we = do_pop;
      if (do_pop) m_lvl--;
      if (do_push) begin
        acc_cnt++;
        if (int'(in_addr) < MEM_WORDS) begin
          sb.push_back('{a: in_addr, d: in_data});
          m_lvl++;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
    if (m_lvl > max_lvl) max_lvl = m_lvl;
  end

  // Monitor: compare status every cycle, pop scoreboard on each write strobe.
  always @(negedge clk) begin
    ent_t e;
    if (mon_en) begin
      chk("mon level", 64'(level), 64'(m_lvl));
      chk("mon in_ready", 64'(in_ready), 64'(m_lvl != DEPTH));
      chk("mon empty", 64'(empty), 64'(m_lvl == 0));
      chk("mon full", 64'(full), 64'(m_lvl == DEPTH));
      chk("mon drop_count", 64'(drop_count), 64'(m_drop));
      chk("mon fb_we", 64'(fb_we), 64'(m_we));
      if (fb_we === 1'b1) begin
        we_cnt++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow: got write addr %0d expected no write", fb_addr);
        end else begin
          e = sb.pop_front();
          chk("sb fb_addr", 64'(fb_addr), 64'(e.a));
          chk("sb fb_data", 64'(fb_data), 64'(e.d));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for single-cycle behaviour right after reset
  // ---------------------------------------------------------------------------
  typedef struct {
    bit                v;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                al;
    int                lvl;
    bit                we;
    int                drop;
  } vec_t;

  vec_t tbl[9];

  int t3_base;
  int t3_acc;
  int guard;

  initial begin
    tbl[0] = '{1'b1, 15'd235,   24'hFFFFFF, 1'b1, 1, 1'b0, 0};
    tbl[1] = '{1'b0, 15'd0,     24'h000000, 1'b1, 0, 1'b1, 0};
    tbl[2] = '{1'b0, 15'd0,     24'h000000, 1'b1, 0, 1'b0, 0};
    tbl[3] = '{1'b1, 15'd19200, 24'h111111, 1'b1, 0, 1'b0, 1};
    tbl[4] = '{1'b1, 15'd32767, 24'h222222, 1'b1, 0, 1'b0, 2};
    tbl[5] = '{1'b1, 15'd19199, 24'h123456, 1'b0, 1, 1'b0, 2};
    tbl[6] = '{1'b0, 15'd0,     24'h000000, 1'b0, 1, 1'b0, 2};
    tbl[7] = '{1'b0, 15'd0,     24'h000000, 1'b1, 0, 1'b1, 2};
    tbl[8] = '{1'b0, 15'd0,     24'h000000, 1'b1, 0, 1'b0, 2};

    rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    flush = 1'b0; fb_allow = 1'b0;
    tick(); tick();
    rst = 1'b1;
    mon_en = 1'b1;
    chk("reset level", 64'(level), 64'd0);
    chk("reset empty", 64'(empty), 64'd1);
    chk("reset full", 64'(full), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset fb_we", 64'(fb_we), 64'd0);
    chk("reset fb_addr", 64'(fb_addr), 64'd0);
    chk("reset fb_data", 64'(fb_data), 64'd0);
    chk("reset drop_count", 64'(drop_count), 64'd0);

    // Test 1 + illegal addresses + legal boundary
    foreach (tbl[i]) begin
      in_valid = tbl[i].v; in_addr = tbl[i].a; in_data = tbl[i].d; fb_allow = tbl[i].al;
      tick();
      chk($sformatf("vec%0d level", i), 64'(level), 64'(tbl[i].lvl));
      chk($sformatf("vec%0d fb_we", i), 64'(fb_we), 64'(tbl[i].we));
      chk($sformatf("vec%0d drop", i), 64'(drop_count), 64'(tbl[i].drop));
      if (i == 1) begin
        chk("vec1 fb_addr", 64'(fb_addr), 64'd235);
        chk("vec1 fb_data", 64'(fb_data), 64'hFFFFFF);
      end
      $display("vec%0d: valid=%0d addr=%0d allow=%0d level=%0d we=%0d drop=%0d",
               i, tbl[i].v, tbl[i].a, tbl[i].al, level, fb_we, drop_count);
    end
    idle_inputs();

    // Test 2: fill to full, refuse 17th, then 16 back-to-back writes
    fb_allow = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_addr = 15'(355 + i); in_data = 24'(24'h100000 + i);
      tick();
    end
    chk("t2 full", 64'(full), 64'd1);
    chk("t2 in_ready", 64'(in_ready), 64'd0);
    in_addr = 15'd371; in_data = 24'hDEAD01;
    tick();
    chk("t2 refused level", 64'(level), 64'd16);
    in_valid = 1'b0; fb_allow = 1'b1; we_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("t2 burst fb_we", 64'(fb_we), 64'd1);
      chk("t2 burst fb_addr", 64'(fb_addr), 64'(355 + i));
    end
    tick();
    chk("t2 end fb_we", 64'(fb_we), 64'd0);
    chk("t2 end empty", 64'(empty), 64'd1);
    chk("t2 pulse count", 64'(we_cnt), 64'd16);
    $display("t2: 16 entries drained, pulses=%0d", we_cnt);

    // Test 3: continuous push with toggling fb_allow across pointer wrap
    we_cnt = 0; max_lvl = 0; t3_base = acc_cnt; fb_allow = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 76; c++) begin
      if (c >= 16) fb_allow = (((c - 16) / 3) % 2) == 0;
      in_addr = 15'(1000 + acc_cnt - t3_base);
      in_data = 24'(24'h300000 + acc_cnt - t3_base);
      tick();
    end
    in_valid = 1'b0; fb_allow = 1'b1;
    t3_acc = acc_cnt - t3_base;
    guard = 0;
    while (level != 0 && guard < 40) begin
      tick(); guard++;
    end
    tick();
    if (guard >= 40) begin
      checks++; failures++;
      $display("FAIL t3_drain_timeout: got level %0d expected 0", level);
    end
    chk("t3 more than 2*DEPTH pushes", 64'(t3_acc > 2 * DEPTH), 64'd1);
    chk("t3 max level", 64'(max_lvl <= DEPTH), 64'd1);
    chk("t3 pulses equal pushes", 64'(we_cnt), 64'(t3_acc));
    chk("t3 scoreboard empty", 64'(sb.size()), 64'd0);
    $display("t3: pushes=%0d pulses=%0d max_level=%0d", t3_acc, we_cnt, max_lvl);

    // Test 5: flush with concurrent push
    fb_allow = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_addr = 15'(500 + i); in_data = 24'(24'h500000 + i);
      tick();
    end
    chk("t5 level before flush", 64'(level), 64'd5);
    flush = 1'b1; in_valid = 1'b1; in_addr = 15'd100; in_data = 24'h0000AA;
    tick();
    idle_inputs();
    chk("t5 level after flush", 64'(level), 64'd0);
    fb_allow = 1'b1; we_cnt = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5 no pulses", 64'(we_cnt), 64'd0);
    chk("t5 drop unchanged", 64'(drop_count), 64'd2);
    in_valid = 1'b1; in_addr = 15'd40; in_data = 24'hABCDEF;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t5 post-flush fb_we", 64'(fb_we), 64'd1);
    chk("t5 post-flush fb_addr", 64'(fb_addr), 64'd40);
    $display("t5: flush cleared queue, pulses=%0d drop=%0d", we_cnt, drop_count);
    tick();

    // Test 6: reset in the middle of a drain
    fb_allow = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_addr = 15'(600 + i); in_data = 24'(24'h600000 + i);
      tick();
    end
    in_valid = 1'b0; fb_allow = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("t6 fb_we", 64'(fb_we), 64'd0);
    chk("t6 level", 64'(level), 64'd0);
    chk("t6 in_ready", 64'(in_ready), 64'd1);
    chk("t6 fb_addr", 64'(fb_addr), 64'd0);
    rst = 1'b1; we_cnt = 0;
    tick(); tick(); tick();
    chk("t6 no pulses after reset", 64'(we_cnt), 64'd0);
    in_valid = 1'b1; in_addr = 15'd777; in_data = 24'h777777;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6 new push fb_we", 64'(fb_we), 64'd1);
    chk("t6 new push fb_addr", 64'(fb_addr), 64'd777);
    chk("t6 new push fb_data", 64'(fb_data), 64'h777777);
    $display("t6: reset mid-drain, new write addr=%0d", fb_addr);
    tick();

    // Test 4: drop_count saturation
    we_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_addr = 15'(20000 + i); in_data = 24'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("t4 drop saturates", 64'(drop_count), 64'd255);
    chk("t4 no pulses", 64'(we_cnt), 64'd0);
    chk("t4 level", 64'(level), 64'd0);
    $display("t4: 300 illegal pushes, drop_count=%0d", drop_count);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
